// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl (with helper full_adder)
// Description : Bit-serial WIDTH-bit adder. One shared 1-bit full adder is
//               stepped LSB-first over the operands, one bit per clock.
//               The sum, carry-out and signed overflow are returned with a
//               one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// full_adder : single-bit full adder shared across all bit positions
// ----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// ----------------------------------------------------------------------------
// serial_adder_ctrl : start/ready sequencer around full_adder
// ----------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    // The counter must hold WIDTH itself after the final step, so it gets
    // one bit more than clog2(WIDTH); it never wraps within an operation.
    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               w_accept;
    logic               w_step;
    logic               w_last;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_overflow;

    logic               w_fa_sum;
    logic               w_fa_carry;
    logic [WIDTH-1:0]   w_res_next;

    // The single shared bit-slice: always fed from the low bits of the
    // shift registers and the running carry.
    full_adder u_fa (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .cin   (r_carry),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    // New sum bit enters at the MSB end so that after WIDTH steps the first
    // computed bit has been shifted down to bit 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_fa_sum;
        end else begin : g_res_wn
            assign w_res_next = {w_fa_sum, r_res_sh[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                // Back-to-back: a start seen during the done cycle is taken
                // exactly as in IDLE.
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand shifting, carry chaining and result capture on the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_res_sh   <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_carry  <= cin;
            r_cnt    <= '0;
            r_res_sh <= '0;
        end else if (w_step) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_res_sh <= w_res_next;
            r_carry  <= w_fa_carry;
            r_cnt    <= r_cnt + c_ONE;
            if (w_last) begin
                // r_carry here is the carry into the MSB slice.
                r_sum      <= w_res_next;
                r_cout     <= w_fa_carry;
                r_overflow <= r_carry ^ w_fa_carry;
            end
        end
    end

    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
//               Expected results come from plain integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [7:0] a0, b0;
    logic [0:0] a1, b1;
    logic       cin0, cin1;
    logic       ready0, busy0, done0, cout0, ovf0;
    logic       ready1, busy1, done1, cout1, ovf1;
    logic [7:0] sum0;
    logic [0:0] sum1;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .cin(cin0),
        .ready(ready0), .busy(busy0), .done(done0), .sum(sum0), .cout(cout0),
        .overflow(ovf0)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .overflow(ovf1)
    );

    task automatic check(string nm, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: unsigned sum modulo 2^(w+1); overflow when the signed sum
    // falls outside the w-bit two's-complement range.
    function automatic exp_t ref_add(int w, logic [31:0] av, logic [31:0] bv, logic cv);
        exp_t   r;
        longint m    = longint'(1) << w;
        longint half = m / 2;
        longint ua   = longint'(av) % m;
        longint ub   = longint'(bv) % m;
        longint full = ua + ub + longint'(cv);
        longint sa   = (ua >= half) ? ua - m : ua;
        longint sb   = (ub >= half) ? ub - m : ub;
        longint s    = sa + sb + longint'(cv);
        r.sum  = 32'(full % m);
        r.cout = (full >= m);
        r.ovf  = (s >= half) || (s < -half);
        r.cyc  = 0;
        return r;
    endfunction

    // Issue one operation to instance k; optionally keep start high with
    // scrambled operands afterwards (they must be ignored while busy).
    task automatic issue(int k, logic [31:0] av, logic [31:0] bv, logic cv, bit hold);
        int   g = 0;
        exp_t e;
        @(negedge clk);
        while (!((k == 0) ? ready0 : ready1)) begin
            g++;
            if (g > 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ready_timeout: actual=0 required=1 (dut%0d)", k);
                return;
            end
            @(negedge clk);
        end
        if (k == 0) begin
            a0 = av[7:0]; b0 = bv[7:0]; cin0 = cv; start0 = 1'b1;
        end else begin
            a1 = av[0:0]; b1 = bv[0:0]; cin1 = cv; start1 = 1'b1;
        end
        @(posedge clk);
        #1;
        e     = ref_add((k == 0) ? 8 : 1, av, bv, cv);
        e.cyc = cyc + ((k == 0) ? 8 : 1);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        if (k == 0) begin
            a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom);
            start0 = hold;
        end else begin
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            start1 = hold;
        end
    endtask

    // Monitor: pops expectations on done, checks latency, busy length, and
    // that results are held steady between completions.
    logic [33:0] held [2];
    int          bcnt [2];
    logic [33:0] m_res;
    logic        m_done, m_busy;
    exp_t        m_e;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                held[k] = '0;
                bcnt[k] = 0;
            end else begin
                m_res  = (k == 0) ? {cout0, ovf0, 24'b0, sum0} : {cout1, ovf1, 31'b0, sum1};
                m_done = (k == 0) ? done0 : done1;
                m_busy = (k == 0) ? busy0 : busy1;
                if (m_busy) bcnt[k]++;
                if (m_done) begin
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL d%0d_unexpected_done: actual=1 required=0", k);
                    end else begin
                        m_e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("d%0d_result", k), 64'(m_res), 64'({m_e.cout, m_e.ovf, m_e.sum}));
                        check($sformatf("d%0d_done_cycle", k), 64'(cyc), 64'(m_e.cyc));
                        check($sformatf("d%0d_busy_len", k), 64'(bcnt[k]), 64'((k == 0) ? 8 : 1));
                    end
                    held[k] = m_res;
                    bcnt[k] = 0;
                end else begin
                    check($sformatf("d%0d_held", k), 64'(m_res), 64'(held[k]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   g;
        rst_n = 1'b0;
        start0 = 1'b1; a0 = 8'h00; b0 = 8'h00; cin0 = 1'b0;
        start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  cin1 = 1'b0;
        #1;
        check("rst_sum", 64'(sum0), 64'h0);
        check("rst_cout_ovf", 64'({cout0, ovf0}), 64'h0);
        check("rst_rdy_busy_done", 64'({ready0, busy0, done0}), 64'b100);
        check("rst_d1", 64'({ready1, busy1, done1, sum1, cout1, ovf1}), 64'b100000);

        // Start already high when reset releases: taken on the first edge.
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        e = ref_add(8, 32'h00, 32'h00, 1'b0);
        e.cyc = cyc + 8;
        q0.push_back(e);
        start0 = 1'b0;
        check("accept_ready_drop", 64'({ready0, busy0}), 64'b01);

        issue(0, 32'h7F, 32'h01, 1'b0, 1'b0);
        issue(0, 32'h80, 32'h80, 1'b0, 1'b0);
        issue(0, 32'hFF, 32'h01, 1'b0, 1'b0);
        issue(0, 32'hA5, 32'h5A, 1'b1, 1'b0);
        issue(0, 32'h03, 32'h04, 1'b0, 1'b1);
        issue(0, 32'h10, 32'h20, 1'b0, 1'b1);
        issue(0, 32'h3C, 32'h4D, 1'b0, 1'b0);

        // Reset in the middle of a run: discarded, no done pulse.
        g = 0;
        @(negedge clk);
        while (!ready0 && g < 100) begin g++; @(negedge clk); end
        a0 = 8'h12; b0 = 8'h34; cin0 = 1'b0; start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrun_busy", 64'(busy0), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        check("midrun_rst_outputs", 64'({sum0, cout0, ovf0}), 64'h0);
        check("midrun_rst_hs", 64'({ready0, busy0, done0}), 64'b100);
        @(negedge clk);
        #1 rst_n = 1'b1;
        issue(0, 32'h01, 32'h01, 1'b0, 1'b0);

        repeat (20) issue(0, $urandom, $urandom, 1'($urandom), 1'($urandom));
        @(negedge clk);
        start0 = 1'b0;

        for (int i = 0; i < 8; i++)
            issue(1, 32'((i >> 2) & 1), 32'((i >> 1) & 1), 1'(i & 1), 1'b0);
        repeat (6) issue(1, $urandom, $urandom, 1'($urandom), 1'($urandom));
        @(negedge clk);
        start1 = 1'b0;

        g = 0;
        while ((q0.size() != 0 || q1.size() != 0) && g < 200) begin
            g++;
            @(negedge clk);
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: actual=%0d pending required=0", q0.size() + q1.size());
        end
        repeat (12) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial N-bit adder sequencer built around one shared 1-bit `full_adder` (ports a, b, cin, sum, carry). It accepts two WIDTH-bit operands and a carry-in over a start/ready handshake. It then steps the full adder through the operand bits LSB-first, one bit per clock, and returns the registered WIDTH-bit sum, carry-out and signed overflow with a one-cycle done pulse. It is the area-minimal alternative to the ripple N-bit adder in the ALU_V1 adder path.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 1..32.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only on a rising edge where ready=1.
- a  in  WIDTH  operand A; sampled on the accept edge only.
- b  in  WIDTH  operand B; sampled on the accept edge only.
- cin  in  1  carry-in; sampled on the accept edge only.
- ready  out  1  high in IDLE and DONE; combinational from state only.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; high in DONE.
- sum  out  WIDTH  result; registered; held until the next completion.
- cout  out  1  carry out of bit WIDTH-1; registered.
- overflow  out  1  two's-complement overflow, equal to the carry into the MSB XOR cout; registered.

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE: if start=1, latch a and b into the shift registers a_sh and b_sh, set carry_q to cin, set cnt to 0, clear res_sh, and go to RUN. Otherwise stay in IDLE.
- RUN, on every edge:
  - Drive the full_adder with a_sh[0], b_sh[0] and carry_q.
  - Shift a_sh and b_sh right by one.
  - Shift the full_adder sum bit into res_sh at the MSB end.
  - Set carry_q to the full_adder carry.
  - Increment cnt.
- RUN, final edge (cnt == WIDTH-1):
  - Load sum with {fa_sum, res_sh[WIDTH-1:1]}. For WIDTH=1, sum = fa_sum.
  - Set cout to fa_carry and overflow to carry_q ^ fa_carry.
  - Go to DONE.
- DONE: done=1 for exactly this cycle.
  - If start=1, accept the new operands exactly as IDLE does and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- start is ignored while busy=1; no queuing and no abort.
- a, b and cin may change freely outside the accept edge.
- Arithmetic: {cout, sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1).
- sum, cout and overflow change only on a completion edge or on reset. They never show partial results.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE; sum=0, cout=0, overflow=0; done=0, busy=0, ready=1. Internal registers are cleared. The block leaves reset on the first rising clk edge after rst_n goes high.
- Accept edge E: busy=1 from E through E+WIDTH-1.
- Completion edge E+WIDTH: results are loaded and done=1 for the cycle after it.
- Latency is WIDTH+1 edges from accept to valid result with done. Throughput is one operation per WIDTH+1 cycles when start is held high.
- cnt width is clog2(WIDTH)+1. cnt never wraps within an operation.
- Reset asserted mid-RUN: the operation is discarded, the outputs return to reset values immediately, and no done pulse is produced.
- start=1 and reset released in the same cycle: start is only accepted on the first edge with rst_n=1.

## Test plan
- Reset, then start with a=00, b=00, cin=0 (WIDTH=8) -> ready drops, busy high for 8 cycles, done pulse on the 9th cycle, sum=00, cout=0, overflow=0.
- a=7F, b=01, cin=0 -> sum=80, cout=0, overflow=1. Also a=80, b=80, cin=0 -> sum=00, cout=1, overflow=1.
- a=FF, b=01, cin=0 -> sum=00, cout=1, overflow=0. Also a=A5, b=5A, cin=1 -> sum=00, cout=1, overflow=0.
- Hold start=1 continuously with operands changing every accept (03+04, then 10+20) -> done pulses spaced 9 cycles apart, sum=07 then 30. Pulses during busy do not alter the results.
- Assert rst_n=0 at cycle 4 of RUN -> outputs are 0 immediately with no done pulse. A subsequent start with a=01, b=01 -> sum=02.
- WIDTH=1: sweep all 8 combinations of {a, b, cin} -> each completes in 2 edges, with sum and cout matching the full-adder truth table.
